mac_accum_unit: RTL and testbench
=================================

Name: mac_accum_unit

Overview:
Downstream consumer of the 8x8 Wallace multiplier's 16-bit product P. It accepts products over a valid/ready handshake and accumulates blocks of up to BLOCK_LEN products into a wide accumulator. Each completed block is presented as a registered sum with count and overflow flag over a second valid/ready handshake. This forms the MAC stage behind the combinational multiplier core.

Parameters:
PW, 16, product width; matches multiplier output P.
AW, 24, accumulator/sum width; must be >= PW.
BLOCK_LEN, 8, maximum products per block; must be >= 1.
CNT_W, $clog2(BLOCK_LEN+1), width of the product counter.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
clr  input  1  synchronous abort; discards the current block.
in_valid  input  1  product available.
in_ready  output  1  unit can accept a product.
in_prod  input  PW  product from multiplier (unsigned).
in_last  input  1  marks the final product of a block (early termination).
out_valid  output  1  block result available.
out_ready  input  1  downstream accepts the result.
out_sum  output  AW  accumulated sum of the block, modulo 2^AW.
out_count  output  CNT_W  number of products in the block (1..BLOCK_LEN).
out_ovf  output  1  sticky: at least one carry out of AW bits occurred during the block.

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low, named rst_n; clk and rst_n follow codebase naming.
- Reset values: state=IDLE; acc=0; cnt=0; ovf=0; out_valid=0; in_ready=1.
- Transfer rules:
  - Input transfer = in_valid & in_ready at a rising edge.
  - Output transfer = out_valid & out_ready at a rising edge.
- in_ready is 1 in IDLE and ACC, 0 in DONE. It is derived from registered state only, with no combinational path from out_ready.
- FSM states: IDLE, ACC, DONE.
- IDLE: on input transfer, acc <= zero-extended in_prod, cnt <= 1, ovf <= 0. Go to DONE if in_last or BLOCK_LEN==1; otherwise go to ACC.
- ACC: on input transfer, {carry, acc} <= acc + in_prod as an (AW+1)-bit add; ovf <= ovf | carry; cnt <= cnt+1. Go to DONE if in_last or cnt+1==BLOCK_LEN. With no transfer, hold all state.
- DONE: out_valid=1. out_sum, out_count and out_ovf are driven directly from acc, cnt and ovf registers.
  - While out_ready=0, all outputs stay stable for any number of cycles.
  - On output transfer, go to IDLE and clear acc, cnt and ovf.
- Latency: out_valid rises on the edge that accepts the final product, so the result is visible the next cycle. One idle cycle (IDLE, in_ready=1) follows each output transfer before a new block starts. A product may be accepted in that IDLE cycle.
- clr (highest priority, synchronous): from any state, go to IDLE; acc, cnt, ovf <= 0; out_valid drops next cycle. A product presented in the same cycle as clr is not accepted, even though in_ready may read 1.
- in_last in IDLE makes a single-product block. in_last while cnt+1==BLOCK_LEN behaves identically to the limit case.
- in_prod and in_last are ignored unless an input transfer occurs.
- Reset asserted mid-block or in DONE: immediate return to reset values. The partial block is lost.
- Overflow wraps modulo 2^AW. ovf is sticky within a block only.
- Outputs are registered and free of X after reset.

Test Plan:
1. Defaults, in_valid held high, products 38000, 12816, 1000, 38097, 20400, 35910, 65025, 446 with no in_last -> one cycle after the 8th acceptance: out_valid=1, out_sum=211694, out_count=8, out_ovf=0; in_ready=0 until out_ready.
2. Early termination: products 1000, 446, 65025 with in_last on the third -> out_sum=66471, out_count=3, out_ovf=0. The next block starts cleanly from acc=0.
3. Overflow: AW=17, BLOCK_LEN=3, three products of 65025 -> out_sum=64003 (195075 mod 131072), out_count=3, out_ovf=1. The next block of 1 with last -> out_ovf=0.
4. Backpressure: in DONE, hold out_ready=0 for 5 cycles with in_valid=1 and varying in_prod -> in_ready=0, no products consumed, outputs bit-stable. Then out_ready=1 for one cycle -> IDLE, in_ready=1.
5. clr mid-block: after 3 products, assert clr with in_valid=1 -> that product is not counted. A subsequent 8-product block of value 1 -> out_sum=8, out_count=8.
6. Async reset: drop rst_n mid-ACC and while in DONE, asynchronously to clk -> out_valid=0, in_ready=1 immediately. After release, a fresh block of 200 and 255 with in_last -> out_sum=455, out_count=2.

Source files
------------

// File: rtl/mac_accum_unit.sv
// mac_accum_unit: accumulates blocks of up to BLOCK_LEN unsigned products
// into an AW-bit sum. Each finished block is held as sum, count and sticky
// overflow until the downstream side accepts it.
module mac_accum_unit #(
  parameter int unsigned PW        = 16,
  parameter int unsigned AW        = 24,
  parameter int unsigned BLOCK_LEN = 8,
  parameter int unsigned CNT_W     = $clog2(BLOCK_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PW-1:0]    in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW-1:0]    out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_BLOCK_LEN = CNT_W'(BLOCK_LEN);
  localparam logic [CNT_W-1:0] LP_ONE       = CNT_W'(1);

  state_t            r_state;
  logic [AW-1:0]     r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf;
  logic              r_in_ready;
  logic              r_out_valid;

  state_t            w_state_nxt;
  logic [AW-1:0]     w_acc_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_ovf_nxt;
  logic [AW:0]       w_sum;
  logic [CNT_W-1:0]  w_cnt_inc;

  // One extra bit on the adder captures the carry out of the accumulator.
  assign w_sum     = (AW+1)'(r_acc) + (AW+1)'(in_prod);
  assign w_cnt_inc = r_cnt + LP_ONE;

  // Next-state and datapath update; clr overrides everything, including a
  // product presented in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    if (clr) begin
      w_state_nxt = S_IDLE;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
      w_ovf_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            w_acc_nxt   = AW'(in_prod);
            w_cnt_nxt   = LP_ONE;
            w_ovf_nxt   = 1'b0;
            w_state_nxt = (in_last || (BLOCK_LEN == 1)) ? S_DONE : S_ACC;
          end
        end
        S_ACC: begin
          if (in_valid) begin
            w_acc_nxt   = w_sum[AW-1:0];
            w_ovf_nxt   = r_ovf | w_sum[AW];
            w_cnt_nxt   = w_cnt_inc;
            if (in_last || (w_cnt_inc == LP_BLOCK_LEN)) begin
              w_state_nxt = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            w_state_nxt = S_IDLE;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_ovf_nxt   = 1'b0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
        end
      endcase
    end
  end

  // State, datapath and handshake flags; flags are precomputed from the next
  // state so they come straight off flops with no path from out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ovf       <= w_ovf_nxt;
      r_in_ready  <= (w_state_nxt != S_DONE);
      r_out_valid <= (w_state_nxt == S_DONE);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_acc;
  assign out_count = r_cnt;
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_mac_accum_unit.sv
// Testbench for mac_accum_unit: default instance (A) plus a narrow
// AW=17 / BLOCK_LEN=3 instance (B) for wrap and overflow behaviour.
module tb_mac_accum_unit;

  typedef struct packed {
    logic [23:0] sum;
    logic [3:0]  cnt;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_clr, a_in_valid, a_in_ready, a_in_last;
  logic        a_out_valid, a_out_ready, a_out_ovf;
  logic [15:0] a_in_prod;
  logic [23:0] a_out_sum;
  logic [3:0]  a_out_count;

  logic        b_clr, b_in_valid, b_in_ready, b_in_last;
  logic        b_out_valid, b_out_ready, b_out_ovf;
  logic [15:0] b_in_prod;
  logic [16:0] b_out_sum;
  logic [1:0]  b_out_count;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  exp_t        a_q[$];
  exp_t        b_q[$];
  logic [63:0] a_msum = '0;
  int unsigned a_mcnt = 0;
  logic [63:0] b_msum = '0;
  int unsigned b_mcnt = 0;

  mac_accum_unit u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (a_clr),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_prod   (a_in_prod),
    .in_last   (a_in_last),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_sum   (a_out_sum),
    .out_count (a_out_count),
    .out_ovf   (a_out_ovf)
  );

  mac_accum_unit #(
    .PW        (16),
    .AW        (17),
    .BLOCK_LEN (3)
  ) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (b_clr),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_prod   (b_in_prod),
    .in_last   (b_in_last),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_sum   (b_out_sum),
    .out_count (b_out_count),
    .out_ovf   (b_out_ovf)
  );

  // ---------------- stimulus / scoreboard helpers ----------------
  task automatic a_send(input logic [15:0] p, input logic last);
    int unsigned n = 0;
    a_in_valid = 1'b1; a_in_prod = p; a_in_last = last;
    while (!a_in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!a_in_ready) begin
      n_checks++;
      $display("FAIL a_send_timeout in_ready=%0b required=1", a_in_ready);
    end else begin
      @(posedge clk); #1;
      a_msum += 64'(p); a_mcnt++;
    end
    a_in_last = 1'b0;
  endtask

  task automatic b_send(input logic [15:0] p, input logic last);
    int unsigned n = 0;
    b_in_valid = 1'b1; b_in_prod = p; b_in_last = last;
    while (!b_in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!b_in_ready) begin
      n_checks++;
      $display("FAIL b_send_timeout in_ready=%0b required=1", b_in_ready);
    end else begin
      @(posedge clk); #1;
      b_msum += 64'(p); b_mcnt++;
    end
    b_in_last = 1'b0;
  endtask

  task automatic push_a();
    exp_t e;
    e.sum = a_msum[23:0];
    e.cnt = 4'(a_mcnt);
    e.ovf = (a_msum >= 64'd16777216);
    a_q.push_back(e);
    a_msum = '0; a_mcnt = 0;
  endtask

  task automatic push_b();
    exp_t e;
    e.sum = {7'd0, b_msum[16:0]};
    e.cnt = 4'(b_mcnt);
    e.ovf = (b_msum >= 64'd131072);
    b_q.push_back(e);
    b_msum = '0; b_mcnt = 0;
  endtask

  task automatic a_collect(output exp_t e, output bit ok);
    int unsigned n = 0;
    e = '0; ok = 1'b0;
    while (!a_out_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (a_out_valid && a_q.size() > 0) begin e = a_q.pop_front(); ok = 1'b1; end
  endtask

  task automatic b_collect(output exp_t e, output bit ok);
    int unsigned n = 0;
    e = '0; ok = 1'b0;
    while (!b_out_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (b_out_valid && b_q.size() > 0) begin e = b_q.pop_front(); ok = 1'b1; end
  endtask

  task automatic a_release();
    a_out_ready = 1'b1; @(posedge clk); #1; a_out_ready = 1'b0;
  endtask

  task automatic b_release();
    b_out_ready = 1'b1; @(posedge clk); #1; b_out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    a_clr = 0; a_in_valid = 0; a_in_prod = '0; a_in_last = 0; a_out_ready = 0;
    b_clr = 0; b_in_valid = 0; b_in_prod = '0; b_in_last = 0; b_out_ready = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({a_out_valid, a_in_ready, a_out_sum, a_out_count, a_out_ovf} !== {1'b0, 1'b1, 24'd0, 4'd0, 1'b0})
      $display("FAIL reset_a got v=%0b r=%0b sum=%0d cnt=%0d ovf=%0b required v=0 r=1 sum=0 cnt=0 ovf=0",
               a_out_valid, a_in_ready, a_out_sum, a_out_count, a_out_ovf);
    else n_pass++;
    n_checks++;
    if ({b_out_valid, b_in_ready, b_out_sum, b_out_count, b_out_ovf} !== {1'b0, 1'b1, 17'd0, 2'd0, 1'b0})
      $display("FAIL reset_b got v=%0b r=%0b sum=%0d cnt=%0d ovf=%0b required v=0 r=1 sum=0 cnt=0 ovf=0",
               b_out_valid, b_in_ready, b_out_sum, b_out_count, b_out_ovf);
    else n_pass++;
  endtask

  task automatic test_full_block();
    logic [15:0] p [8] = '{16'd38000, 16'd12816, 16'd1000, 16'd38097,
                           16'd20400, 16'd35910, 16'd65025, 16'd446};
    exp_t e; bit ok;
    for (int i = 0; i < 8; i++) begin
      a_send(p[i], 1'b0);
      if (i == 6) begin
        n_checks++;
        if (a_out_valid !== 1'b0)
          $display("FAIL full_pre_valid got=%0b required=0", a_out_valid);
        else n_pass++;
      end
    end
    a_in_valid = 1'b0;
    push_a();
    n_checks++;
    if ({a_out_valid, a_in_ready} !== 2'b10)
      $display("FAIL full_latency got v=%0b r=%0b required v=1 r=0", a_out_valid, a_in_ready);
    else n_pass++;
    a_collect(e, ok);
    n_checks++;
    if (!ok || {a_out_sum, a_out_count, a_out_ovf} !== {e.sum, e.cnt, e.ovf})
      $display("FAIL full_result got sum=%0d cnt=%0d ovf=%0b required sum=%0d cnt=%0d ovf=%0b ok=%0b",
               a_out_sum, a_out_count, a_out_ovf, e.sum, e.cnt, e.ovf, ok);
    else n_pass++;
    a_release();
    n_checks++;
    if ({a_out_valid, a_in_ready} !== 2'b01)
      $display("FAIL full_release got v=%0b r=%0b required v=0 r=1", a_out_valid, a_in_ready);
    else n_pass++;
  endtask

  task automatic test_early_last();
    exp_t e; bit ok;
    a_send(16'd1000, 1'b0); a_send(16'd446, 1'b0); a_send(16'd65025, 1'b1);
    a_in_valid = 1'b0;
    push_a();
    a_collect(e, ok);
    n_checks++;
    if (!ok || {a_out_sum, a_out_count, a_out_ovf} !== {e.sum, e.cnt, e.ovf})
      $display("FAIL early_result got sum=%0d cnt=%0d ovf=%0b required sum=%0d cnt=%0d ovf=%0b",
               a_out_sum, a_out_count, a_out_ovf, e.sum, e.cnt, e.ovf);
    else n_pass++;
    a_release();
    a_send(16'd7, 1'b1);
    a_in_valid = 1'b0;
    push_a();
    a_collect(e, ok);
    n_checks++;
    if (!ok || {a_out_sum, a_out_count, a_out_ovf} !== {e.sum, e.cnt, e.ovf})
      $display("FAIL early_single got sum=%0d cnt=%0d ovf=%0b required sum=%0d cnt=%0d ovf=%0b",
               a_out_sum, a_out_count, a_out_ovf, e.sum, e.cnt, e.ovf);
    else n_pass++;
    a_release();
  endtask

  task automatic test_overflow();
    exp_t e; bit ok;
    // Limit-terminated, single-with-last, then last on the limit product.
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        b_send(16'd65025, 1'b1);
      end else begin
        b_send(16'd65025, 1'b0); b_send(16'd65025, 1'b0);
        b_send(16'd65025, (k == 2));
      end
      b_in_valid = 1'b0;
      push_b();
      b_collect(e, ok);
      n_checks++;
      if (!ok || {b_out_sum, b_out_count, b_out_ovf} !== {e.sum[16:0], e.cnt[1:0], e.ovf})
        $display("FAIL ovf_block%0d got sum=%0d cnt=%0d ovf=%0b required sum=%0d cnt=%0d ovf=%0b",
                 k, b_out_sum, b_out_count, b_out_ovf, e.sum, e.cnt, e.ovf);
      else n_pass++;
      b_release();
    end
  endtask

  task automatic test_backpressure();
    exp_t e; bit ok;
    a_send(16'd300, 1'b0); a_send(16'd500, 1'b1);
    push_a();
    e = (a_q.size() > 0) ? a_q[0] : '0;
    a_in_valid = 1'b1; a_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_in_prod = 16'(1000 * i + 1);
      a_in_last = i[0];
      @(posedge clk); #1;
      n_checks++;
      if ({a_out_valid, a_in_ready, a_out_sum, a_out_count, a_out_ovf} !== {1'b1, 1'b0, e.sum, e.cnt, e.ovf})
        $display("FAIL bp_hold%0d got v=%0b r=%0b sum=%0d cnt=%0d required v=1 r=0 sum=%0d cnt=%0d",
                 i, a_out_valid, a_in_ready, a_out_sum, a_out_count, e.sum, e.cnt);
      else n_pass++;
    end
    a_in_valid = 1'b0; a_in_last = 1'b0;
    a_collect(e, ok);
    n_checks++;
    if (!ok || {a_out_sum, a_out_count, a_out_ovf} !== {e.sum, e.cnt, e.ovf})
      $display("FAIL bp_result got sum=%0d cnt=%0d required sum=%0d cnt=%0d", a_out_sum, a_out_count, e.sum, e.cnt);
    else n_pass++;
    a_release();
    n_checks++;
    if ({a_out_valid, a_in_ready} !== 2'b01)
      $display("FAIL bp_release got v=%0b r=%0b required v=0 r=1", a_out_valid, a_in_ready);
    else n_pass++;
    // Back-to-back: accepted in the idle cycle right after the output transfer.
    a_send(16'd9, 1'b1);
    a_in_valid = 1'b0;
    push_a();
    a_collect(e, ok);
    n_checks++;
    if (!ok || {a_out_sum, a_out_count, a_out_ovf} !== {e.sum, e.cnt, e.ovf})
      $display("FAIL back_to_back got sum=%0d cnt=%0d required sum=%0d cnt=%0d", a_out_sum, a_out_count, e.sum, e.cnt);
    else n_pass++;
    a_release();
  endtask

  task automatic test_clr();
    exp_t e; bit ok;
    a_send(16'd10, 1'b0); a_send(16'd20, 1'b0); a_send(16'd30, 1'b0);
    a_clr = 1'b1; a_in_prod = 16'd5000; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_clr = 1'b0; a_in_valid = 1'b0;
    a_msum = '0; a_mcnt = 0;
    n_checks++;
    if ({a_out_valid, a_in_ready, a_out_count} !== {1'b0, 1'b1, 4'd0})
      $display("FAIL clr_acc got v=%0b r=%0b cnt=%0d required v=0 r=1 cnt=0", a_out_valid, a_in_ready, a_out_count);
    else n_pass++;
    for (int i = 0; i < 8; i++) a_send(16'd1, 1'b0);
    a_in_valid = 1'b0;
    push_a();
    a_collect(e, ok);
    n_checks++;
    if (!ok || {a_out_sum, a_out_count, a_out_ovf} !== {e.sum, e.cnt, e.ovf})
      $display("FAIL clr_next got sum=%0d cnt=%0d required sum=%0d cnt=%0d", a_out_sum, a_out_count, e.sum, e.cnt);
    else n_pass++;
    a_release();
    // clr while a result is waiting discards it.
    a_send(16'd4, 1'b1);
    a_in_valid = 1'b0;
    a_msum = '0; a_mcnt = 0;
    a_clr = 1'b1; @(posedge clk); #1; a_clr = 1'b0;
    n_checks++;
    if ({a_out_valid, a_in_ready, a_out_sum} !== {1'b0, 1'b1, 24'd0})
      $display("FAIL clr_done got v=%0b r=%0b sum=%0d required v=0 r=1 sum=0", a_out_valid, a_in_ready, a_out_sum);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    exp_t e; bit ok;
    a_send(16'd100, 1'b0); a_send(16'd200, 1'b0);
    a_in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_out_valid, a_in_ready, a_out_sum, a_out_count} !== {1'b0, 1'b1, 24'd0, 4'd0})
      $display("FAIL rst_acc got v=%0b r=%0b sum=%0d cnt=%0d required v=0 r=1 sum=0 cnt=0",
               a_out_valid, a_in_ready, a_out_sum, a_out_count);
    else n_pass++;
    #2 rst_n = 1'b1;
    a_msum = '0; a_mcnt = 0;
    @(posedge clk); #1;
    a_send(16'd11, 1'b1);
    a_in_valid = 1'b0;
    push_a();
    a_collect(e, ok);
    n_checks++;
    if (!ok || {a_out_sum, a_out_count, a_out_ovf} !== {e.sum, e.cnt, e.ovf})
      $display("FAIL rst_acc_next got sum=%0d cnt=%0d required sum=%0d cnt=%0d", a_out_sum, a_out_count, e.sum, e.cnt);
    else n_pass++;
    a_release();
    a_send(16'd50, 1'b0); a_send(16'd60, 1'b1);
    a_in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_out_valid, a_in_ready, a_out_sum, a_out_count} !== {1'b0, 1'b1, 24'd0, 4'd0})
      $display("FAIL rst_done got v=%0b r=%0b sum=%0d cnt=%0d required v=0 r=1 sum=0 cnt=0",
               a_out_valid, a_in_ready, a_out_sum, a_out_count);
    else n_pass++;
    #2 rst_n = 1'b1;
    a_msum = '0; a_mcnt = 0;
    @(posedge clk); #1;
    a_send(16'd200, 1'b0); a_send(16'd255, 1'b1);
    a_in_valid = 1'b0;
    push_a();
    a_collect(e, ok);
    n_checks++;
    if (!ok || {a_out_sum, a_out_count, a_out_ovf} !== {e.sum, e.cnt, e.ovf})
      $display("FAIL rst_fresh got sum=%0d cnt=%0d required sum=%0d cnt=%0d", a_out_sum, a_out_count, e.sum, e.cnt);
    else n_pass++;
    a_release();
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_early_last();
    test_overflow();
    test_backpressure();
    test_clr();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
